// File: rtl/game_pkg.sv
// Shared playfield constants, lane direction encoding and the divider reload clamp.
package game_pkg;

    localparam int unsigned GRID_W = 20;
    localparam int unsigned POS_W  = 5;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // A shifted-out speed of zero would stall the lane; one step per cycle is the fastest legal rate.
    function automatic logic [31:0] clamp_reload(input logic [31:0] shifted);
        return (shifted == '0) ? 32'd1 : shifted;
    endfunction

endpackage

// File: rtl/car_lane.sv
// One traffic lane: speed divider, wrap-around column register and step pulse.
module car_lane
    import game_pkg::dir_e, game_pkg::DIR_RIGHT, game_pkg::clamp_reload;
#(
    parameter int unsigned      GRID_W = game_pkg::GRID_W,
    parameter int unsigned      POS_W  = game_pkg::POS_W,
    parameter int unsigned      DIV_W  = 24,
    parameter logic [POS_W-1:0] START  = '0,
    parameter logic [DIV_W-1:0] SPEED  = DIV_W'(1),
    parameter dir_e             DIR    = DIR_RIGHT
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_enable,
    input  logic             i_restart,
    input  logic [2:0]       i_level,
    output logic [POS_W-1:0] o_x,
    output logic             o_step
);

    localparam logic [DIV_W-1:0] RST_CNT = DIV_W'(clamp_reload(32'(SPEED))) - 1'b1;
    localparam logic [POS_W-1:0] LAST    = POS_W'(GRID_W - 1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] shifted;
    logic [DIV_W-1:0] reload_m1;
    logic [POS_W-1:0] next_x;

    always_comb begin
        shifted   = SPEED >> i_level;
        reload_m1 = DIV_W'(clamp_reload(32'(shifted))) - 1'b1;
        next_x    = o_x;
        if (DIR == DIR_RIGHT) begin
            next_x = (o_x == LAST) ? '0 : o_x + 1'b1;
        end else begin
            next_x = (o_x == '0) ? LAST : o_x - 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_x    <= START;
            cnt    <= RST_CNT;
            o_step <= 1'b0;
        end else if (i_restart) begin
            o_x    <= START;
            cnt    <= reload_m1;
            o_step <= 1'b0;
        end else if (i_enable) begin
            if (cnt == '0) begin
                o_x    <= next_x;
                cnt    <= reload_m1;
                o_step <= 1'b1;
            end else begin
                cnt    <= cnt - 1'b1;
                o_step <= 1'b0;
            end
        end else begin
            o_step <= 1'b0;
        end
    end

endmodule

// File: rtl/car_lanes.sv
// Road-section traffic: NUM_LANES independent car_lane instances plus the registered frog-hit check.
module car_lanes
    import game_pkg::dir_e;
#(
    parameter int unsigned                NUM_LANES  = 4,
    parameter int unsigned                GRID_W     = game_pkg::GRID_W,
    parameter int unsigned                POS_W      = game_pkg::POS_W,
    parameter int unsigned                DIV_W      = 24,
    parameter logic [NUM_LANES*POS_W-1:0] LANE_START = {5'd0, 5'd6, 5'd12, 5'd19},
    parameter logic [NUM_LANES*DIV_W-1:0] LANE_SPEED = {4{24'd2_500_000}},
    parameter logic [NUM_LANES-1:0]       LANE_DIR   = 4'b0101
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_n,
    input  logic                       i_enable,
    input  logic                       i_restart,
    input  logic [2:0]                 i_level,
    input  logic [POS_W-1:0]           i_frog_x,
    input  logic [2:0]                 i_frog_lane,
    input  logic                       i_frog_on_road,
    output logic [NUM_LANES*POS_W-1:0] o_car_x,
    output logic [NUM_LANES-1:0]       o_step,
    output logic                       o_hit
);

    if (NUM_LANES < 1 || NUM_LANES > 8) begin : g_bad_lanes
        $error("car_lanes: NUM_LANES must be 1..8");
    end
    if ((64'd1 << POS_W) < 64'(GRID_W)) begin : g_bad_pos_w
        $error("car_lanes: POS_W too narrow for GRID_W");
    end
    if (DIV_W > 32) begin : g_bad_div_w
        $error("car_lanes: DIV_W must not exceed 32");
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        if (32'(LANE_START[i*POS_W +: POS_W]) >= GRID_W) begin : g_bad_start
            $error("car_lanes: lane start column outside the row");
        end

        car_lane #(
            .GRID_W (GRID_W),
            .POS_W  (POS_W),
            .DIV_W  (DIV_W),
            .START  (LANE_START[i*POS_W +: POS_W]),
            .SPEED  (LANE_SPEED[i*DIV_W +: DIV_W]),
            .DIR    (dir_e'(LANE_DIR[i]))
        ) u_lane (
            .i_Clk     (i_Clk),
            .i_Rst_n   (i_Rst_n),
            .i_enable  (i_enable),
            .i_restart (i_restart),
            .i_level   (i_level),
            .o_x       (o_car_x[i*POS_W +: POS_W]),
            .o_step    (o_step[i])
        );
    end

    logic [POS_W-1:0] sel_x;
    logic             lane_ok;

    // Lane indices with no instance leave lane_ok low, so they can never hit.
    always_comb begin
        sel_x   = '0;
        lane_ok = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (32'(i_frog_lane) == i) begin
                sel_x   = o_car_x[i*POS_W +: POS_W];
                lane_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_hit <= 1'b0;
        end else begin
            o_hit <= i_frog_on_road && lane_ok && (sel_x == i_frog_x);
        end
    end

endmodule

// File: tb/tb_car_lanes.sv
// Directed and randomised checks of car_lanes against a per-lane elapsed-cycle reference model.
module tb_car_lanes;

    localparam int unsigned NL = 4;
    localparam int unsigned GW = 20;
    localparam int unsigned PW = 5;
    localparam int unsigned DW = 24;
    localparam logic [NL*PW-1:0] START_PK = {5'd10, 5'd6, 5'd0, 5'd18};
    localparam logic [NL*DW-1:0] SPEED_PK = {24'd7, 24'd100, 24'd2, 24'd3};
    localparam logic [NL-1:0]    DIR_PK   = 4'b0101;

    localparam int unsigned ST[NL]  = '{18, 0, 6, 10};
    localparam int unsigned SP[NL]  = '{3, 2, 100, 7};
    localparam bit          RGT[NL] = '{1'b1, 1'b0, 1'b1, 1'b0};

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            restart;
    logic [2:0]      level;
    logic [PW-1:0]   frog_x;
    logic [2:0]      frog_lane;
    logic            on_road;
    logic [NL*PW-1:0] car_x;
    logic [NL-1:0]   step;
    logic            hit;

    car_lanes #(
        .NUM_LANES  (NL),
        .GRID_W     (GW),
        .POS_W      (PW),
        .DIV_W      (DW),
        .LANE_START (START_PK),
        .LANE_SPEED (SPEED_PK),
        .LANE_DIR   (DIR_PK)
    ) dut (
        .i_Clk          (clk),
        .i_Rst_n        (rst_n),
        .i_enable       (en),
        .i_restart      (restart),
        .i_level        (level),
        .i_frog_x       (frog_x),
        .i_frog_lane    (frog_lane),
        .i_frog_on_road (on_road),
        .o_car_x        (car_x),
        .o_step         (step),
        .o_hit          (hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL*PW-1:0] x;
        logic [NL-1:0]    st;
        logic             h;
    } exp_t;

    exp_t        sb[$];
    bit          sb_on = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned m_x[NL];
    int unsigned m_period[NL];
    int unsigned m_elapsed[NL];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned clampr(input int unsigned s, input int unsigned lvl);
        int unsigned v;
        v = s >> lvl;
        return (v == 0) ? 1 : v;
    endfunction

    // Predict the outputs after the coming edge from the current inputs, then advance the model.
    task automatic push_expect();
        exp_t e;
        e.h  = on_road && (frog_lane < NL) && (m_x[frog_lane[1:0]] == 32'(frog_x));
        e.st = '0;
        for (int l = 0; l < NL; l++) begin
            if (restart) begin
                m_x[l]       = ST[l];
                m_period[l]  = clampr(SP[l], level);
                m_elapsed[l] = 0;
            end else if (en) begin
                m_elapsed[l]++;
                if (m_elapsed[l] == m_period[l]) begin
                    e.st[l]      = 1'b1;
                    m_x[l]       = RGT[l] ? (m_x[l] + 1) % GW : (m_x[l] + GW - 1) % GW;
                    m_elapsed[l] = 0;
                    m_period[l]  = clampr(SP[l], level);
                end
            end
            e.x[l*PW +: PW] = PW'(m_x[l]);
        end
        sb.push_back(e);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            push_expect();
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_on && sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_car_x", 32'(car_x), 32'(e.x));
                chk("sb_step", 32'(step), 32'(e.st));
                chk("sb_hit", 32'(hit), 32'(e.h));
            end
        end
    end

    initial begin
        int unsigned tries;
        rst_n     = 1'b0;
        en        = 1'b1;
        restart   = 1'b0;
        level     = 3'd0;
        frog_x    = 5'd18;
        frog_lane = 3'd0;
        on_road   = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_car_x", 32'(car_x), 32'(START_PK));
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);

        for (int l = 0; l < NL; l++) begin
            m_x[l]       = ST[l];
            m_period[l]  = clampr(SP[l], 0);
            m_elapsed[l] = 0;
        end
        on_road = 1'b0;
        rst_n   = 1'b1;
        sb_on   = 1'b1;

        tick(2);
        chk("lane1_first_left", 32'(car_x[1*PW +: PW]), 32'd19);
        chk("lane0_hold", 32'(car_x[0*PW +: PW]), 32'd18);
        tick(1);
        chk("lane0_first_right", 32'(car_x[0*PW +: PW]), 32'd19);
        chk("lane0_step_pulse", 32'(step[0]), 32'd1);
        tick(1);
        chk("lane1_second_left", 32'(car_x[1*PW +: PW]), 32'd18);
        chk("lane0_step_drop", 32'(step[0]), 32'd0);
        tick(5);
        chk("lane0_wrapped", 32'(car_x[0*PW +: PW]), 32'd1);

        frog_lane = 3'd2;
        frog_x    = 5'd6;
        on_road   = 1'b1;
        tick(1);
        chk("hit_lane2", 32'(hit), 32'd1);
        frog_lane = 3'd5;
        tick(1);
        chk("hit_bad_lane", 32'(hit), 32'd0);
        frog_lane = 3'd2;
        on_road   = 1'b0;
        tick(1);
        chk("hit_off_road", 32'(hit), 32'd0);

        en = 1'b0;
        tick(10);
        chk("frozen_step", 32'(step), 32'd0);
        en = 1'b1;
        tick(10);

        tries = 0;
        while (m_elapsed[0] != m_period[0] - 1 && tries < 10) begin
            tick(1);
            tries++;
        end
        chk("restart_align", 32'(m_elapsed[0] == m_period[0] - 1), 32'd1);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("restart_x", 32'(car_x), 32'(START_PK));
        chk("restart_step", 32'(step), 32'd0);
        tick(2);
        chk("restart_wait", 32'(step[0]), 32'd0);
        tick(1);
        chk("restart_full_interval", 32'(car_x[0*PW +: PW]), 32'd19);

        level   = 3'd7;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(3);
        chk("level7_step_all", 32'(step), 32'hF);
        tick(4);
        chk("level7_step_hold", 32'(step), 32'hF);

        level = 3'd1;
        for (int k = 0; k < 400; k++) begin
            en        = ($urandom_range(3) != 0);
            restart   = ($urandom_range(49) == 0);
            if ($urandom_range(19) == 0) level = 3'($urandom_range(7));
            frog_lane = 3'($urandom_range(7));
            on_road   = ($urandom_range(3) != 0);
            frog_x    = ($urandom_range(1) == 0) ? PW'(m_x[frog_lane[1:0]]) : PW'($urandom_range(GW - 1));
            tick(1);
        end
        restart = 1'b0;

        sb_on = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
